// File: rtl/multiplier_cpa_stage.sv
// Two-stage carry-propagate adder resolving a carry-save product into a 32-bit result.
// Optional stall counter output perf_stall is enabled by defining MULTIPLIER_CPA_PERF_EN.
module multiplier_cpa_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_carry,
  input  logic [31:0]      in_sum,
  input  logic [1:0]       in_sew,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
`ifdef MULTIPLIER_CPA_PERF_EN
  output logic [15:0]      perf_stall,
`endif
  output logic [TAG_W-1:0] out_tag
);

  logic             r_s1_valid;
  logic [15:0]      r_s1_low;
  logic             r_s1_c16;
  logic [15:0]      r_s1_hi_carry;
  logic [15:0]      r_s1_hi_sum;
  logic             r_s1_sew0;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [31:0]      r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic [16:0]      w_low_sum;
  logic [15:0]      w_high_sum;
  logic             w_carry_in;
  logic             w_s2_load;
  logic             w_unused_sew;

  // Only the packed-lane flag matters; the upper element-width bit is ignored.
  assign w_unused_sew = in_sew[1];

  assign w_s2_load  = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign w_low_sum  = {1'b0, in_carry[15:0]} + {1'b0, in_sum[15:0]};
  // Packed 8x8 lanes must not ripple a carry from the low half into the high half.
  assign w_carry_in = r_s1_c16 && !r_s1_sew0;
  assign w_high_sum = r_s1_hi_carry + r_s1_hi_sum + {15'b0, w_carry_in};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid    <= 1'b0;
      r_s1_low      <= '0;
      r_s1_c16      <= 1'b0;
      r_s1_hi_carry <= '0;
      r_s1_hi_sum   <= '0;
      r_s1_sew0     <= 1'b0;
      r_s1_tag      <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_low      <= w_low_sum[15:0];
        r_s1_c16      <= w_low_sum[16];
        r_s1_hi_carry <= in_carry[31:16];
        r_s1_hi_sum   <= in_sum[31:16];
        r_s1_sew0     <= in_sew[0];
        r_s1_tag      <= in_tag;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= {w_high_sum, r_s1_low};
        r_out_tag    <= r_s1_tag;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

`ifdef MULTIPLIER_CPA_PERF_EN
  logic [15:0] r_perf_stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
    end else if (r_out_valid && !out_ready && (r_perf_stall != 16'hFFFF)) begin
      r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_stall = r_perf_stall;
`endif

endmodule
